// File: rtl/ecc_ram_op_sequencer_if.sv
// ecc_ram_op_sequencer_if
//   Bundles every non-clock signal of the ECC operand-RAM microsequencer.
//   Control side : start, start_pc -> busy, done, err
//   Program ROM  : prog_addr -> prog_data (1-cycle registered ROM)
//   RAM port a   : a_w, a_adbus, a_data_in -> a_data_out (1-cycle read)
//   RAM port b   : b_w, b_adbus -> b_data_out (read only)
//   Arith unit   : unit_start, unit_op, opnd_a, opnd_b -> unit_done, unit_result
//   modport master : the sequencer itself
//   modport slave  : everything around it (control, ROM, RAM, unit)
interface ecc_ram_op_sequencer_if #(
    parameter int unsigned DATA = 256,
    parameter int unsigned ADDR = 6,
    parameter int unsigned PC_W = 8
);
    logic            start;
    logic [PC_W-1:0] start_pc;
    logic            busy;
    logic            done;
    logic            err;

    logic [PC_W-1:0] prog_addr;
    logic [19:0]     prog_data;

    logic            a_w;
    logic [ADDR-1:0] a_adbus;
    logic [DATA-1:0] a_data_in;
    logic [DATA-1:0] a_data_out;

    logic            b_w;
    logic [ADDR-1:0] b_adbus;
    logic [DATA-1:0] b_data_out;

    logic            unit_start;
    logic [1:0]      unit_op;
    logic [DATA-1:0] opnd_a;
    logic [DATA-1:0] opnd_b;
    logic            unit_done;
    logic [DATA-1:0] unit_result;

    modport master (
        input  start, start_pc, prog_data, a_data_out, b_data_out,
               unit_done, unit_result,
        output busy, done, err, prog_addr, a_w, a_adbus, a_data_in,
               b_w, b_adbus, unit_start, unit_op, opnd_a, opnd_b
    );

    modport slave (
        output start, start_pc, prog_data, a_data_out, b_data_out,
               unit_done, unit_result,
        input  busy, done, err, prog_addr, a_w, a_adbus, a_data_in,
               b_w, b_adbus, unit_start, unit_op, opnd_a, opnd_b
    );
endinterface

// File: rtl/ecc_ram_op_sequencer.sv
// ecc_ram_op_sequencer
//   Microsequencer for the ECC datapath. Fetches 20-bit instructions
//   {op, dst, srcA, srcB} from an external program ROM, reads two operands
//   from the shared dual-port operand RAM, launches the field arithmetic
//   unit and writes its result back through RAM port a.
//   Opcodes: 00 END, 01 MUL, 10 ADD, 11 SQR (SQR squares RAM[srcA]).
//   Ports:
//     i_clk  : clock, all state changes on rising edge
//     i_rst  : asynchronous active-high reset
//     io_seq : ecc_ram_op_sequencer_if.master (control, ROM, RAM, unit)
//   All outputs are registered; b_w is tied low.
module ecc_ram_op_sequencer #(
    parameter int unsigned DATA    = 256,
    parameter int unsigned ADDR    = 6,
    parameter int unsigned PC_W    = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    ecc_ram_op_sequencer_if.master io_seq
);

    localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_READ, S_EXEC, S_WAIT, S_WRITE, S_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_END = 2'b00,
        OP_MUL = 2'b01,
        OP_ADD = 2'b10,
        OP_SQR = 2'b11
    } op_e;

    state_e          r_state, w_state_n;
    logic [PC_W-1:0] r_pc, w_pc_n;
    logic [1:0]      r_op, w_op_n;
    logic [5:0]      r_dst, w_dst_n;
    logic [WD_W-1:0] r_wdog, w_wdog_n;
    logic            r_busy, w_busy_n;
    logic            r_done, w_done_n;
    logic            r_err, w_err_n;
    logic            r_a_w, w_a_w_n;
    logic [ADDR-1:0] r_a_adbus, w_a_adbus_n;
    logic [DATA-1:0] r_a_data_in, w_a_data_in_n;
    logic [ADDR-1:0] r_b_adbus, w_b_adbus_n;
    logic            r_unit_start, w_unit_start_n;
    logic [1:0]      r_unit_op, w_unit_op_n;
    logic [DATA-1:0] r_opnd_a, w_opnd_a_n;
    logic [DATA-1:0] r_opnd_b, w_opnd_b_n;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_op         <= '0;
            r_dst        <= '0;
            r_wdog       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_a_w        <= 1'b0;
            r_a_adbus    <= '0;
            r_a_data_in  <= '0;
            r_b_adbus    <= '0;
            r_unit_start <= 1'b0;
            r_unit_op    <= '0;
            r_opnd_a     <= '0;
            r_opnd_b     <= '0;
        end else begin
            r_state      <= w_state_n;
            r_pc         <= w_pc_n;
            r_op         <= w_op_n;
            r_dst        <= w_dst_n;
            r_wdog       <= w_wdog_n;
            r_busy       <= w_busy_n;
            r_done       <= w_done_n;
            r_err        <= w_err_n;
            r_a_w        <= w_a_w_n;
            r_a_adbus    <= w_a_adbus_n;
            r_a_data_in  <= w_a_data_in_n;
            r_b_adbus    <= w_b_adbus_n;
            r_unit_start <= w_unit_start_n;
            r_unit_op    <= w_unit_op_n;
            r_opnd_a     <= w_opnd_a_n;
            r_opnd_b     <= w_opnd_b_n;
        end
    end

    // Outputs are registered, so each transition computes the value the
    // outputs must show in the destination state. Pulses (done, a_w,
    // unit_start) default low and are raised only on the entering edge.
    always_comb begin
        w_state_n      = r_state;
        w_pc_n         = r_pc;
        w_op_n         = r_op;
        w_dst_n        = r_dst;
        w_wdog_n       = r_wdog;
        w_busy_n       = r_busy;
        w_done_n       = 1'b0;
        w_err_n        = r_err;
        w_a_w_n        = 1'b0;
        w_a_adbus_n    = r_a_adbus;
        w_a_data_in_n  = r_a_data_in;
        w_b_adbus_n    = r_b_adbus;
        w_unit_start_n = 1'b0;
        w_unit_op_n    = r_unit_op;
        w_opnd_a_n     = r_opnd_a;
        w_opnd_b_n     = r_opnd_b;

        case (r_state)
            S_IDLE: begin
                if (io_seq.start) begin
                    w_pc_n    = io_seq.start_pc;
                    w_busy_n  = 1'b1;
                    w_err_n   = 1'b0;
                    w_state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_n = S_DECODE;
            end
            S_DECODE: begin
                // Source addresses come straight from the ROM word so the
                // RAM sees them one cycle earlier; only op/dst are kept.
                w_op_n  = io_seq.prog_data[19:18];
                w_dst_n = io_seq.prog_data[17:12];
                if (op_e'(io_seq.prog_data[19:18]) == OP_END) begin
                    w_busy_n  = 1'b0;
                    w_done_n  = 1'b1;
                    w_state_n = S_DONE;
                end else begin
                    w_a_adbus_n = ADDR'(io_seq.prog_data[11:6]);
                    w_b_adbus_n = ADDR'(io_seq.prog_data[5:0]);
                    w_state_n   = S_READ;
                end
            end
            S_READ: begin
                w_state_n = S_EXEC;
            end
            S_EXEC: begin
                w_opnd_a_n     = io_seq.a_data_out;
                w_opnd_b_n     = (op_e'(r_op) == OP_SQR) ? io_seq.a_data_out
                                                         : io_seq.b_data_out;
                w_unit_op_n    = r_op;
                w_unit_start_n = 1'b1;
                w_wdog_n       = '0;
                w_state_n      = S_WAIT;
            end
            S_WAIT: begin
                if (io_seq.unit_done) begin
                    w_a_w_n       = 1'b1;
                    w_a_adbus_n   = ADDR'(r_dst);
                    w_a_data_in_n = io_seq.unit_result;
                    w_state_n     = S_WRITE;
                end else if (r_wdog == WD_LAST) begin
                    w_err_n   = 1'b1;
                    w_busy_n  = 1'b0;
                    w_done_n  = 1'b1;
                    w_state_n = S_DONE;
                end else begin
                    w_wdog_n = r_wdog + 1'b1;
                end
            end
            S_WRITE: begin
                // Running off the end of program memory is an error, not a wrap.
                if (r_pc == '1) begin
                    w_err_n   = 1'b1;
                    w_busy_n  = 1'b0;
                    w_done_n  = 1'b1;
                    w_state_n = S_DONE;
                end else begin
                    w_pc_n    = r_pc + 1'b1;
                    w_state_n = S_FETCH;
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    assign io_seq.busy       = r_busy;
    assign io_seq.done       = r_done;
    assign io_seq.err        = r_err;
    assign io_seq.prog_addr  = r_pc;
    assign io_seq.a_w        = r_a_w;
    assign io_seq.a_adbus    = r_a_adbus;
    assign io_seq.a_data_in  = r_a_data_in;
    assign io_seq.b_w        = 1'b0;
    assign io_seq.b_adbus    = r_b_adbus;
    assign io_seq.unit_start = r_unit_start;
    assign io_seq.unit_op    = r_unit_op;
    assign io_seq.opnd_a     = r_opnd_a;
    assign io_seq.opnd_b     = r_opnd_b;

endmodule
